// File: rtl/rv_plic_claim_ctrl_if.sv
// Gateway and service-agent signal bundle for rv_plic_claim_ctrl.
// The master modport is the claim controller. The slave modport is the gateway/agent side.
interface rv_plic_claim_ctrl_if #(
    parameter int N_SOURCE = 32,
    parameter int PRIO_W   = 3,
    parameter int ID_W     = $clog2(N_SOURCE + 1)
);
    logic [N_SOURCE-1:0]        ip;
    logic [N_SOURCE-1:0]        ie;
    logic [N_SOURCE*PRIO_W-1:0] prio;
    logic [PRIO_W-1:0]          threshold;
    logic [N_SOURCE-1:0]        claim;
    logic [N_SOURCE-1:0]        complete;
    logic                       irq_o;
    logic                       svc_valid_o;
    logic [ID_W-1:0]            svc_id_o;
    logic                       svc_ready_i;
    logic                       done_i;
    logic                       busy_o;
    logic                       timeout_o;

    modport master (
        input  ip, ie, prio, threshold, svc_ready_i, done_i,
        output claim, complete, irq_o, svc_valid_o, svc_id_o, busy_o, timeout_o
    );

    modport slave (
        output ip, ie, prio, threshold, svc_ready_i, done_i,
        input  claim, complete, irq_o, svc_valid_o, svc_id_o, busy_o, timeout_o
    );
endinterface

// File: rtl/rv_plic_claim_ctrl.sv
// PLIC target claim/complete engine. It claims the best eligible source, hands its ID to a service agent, then completes it.
// The optional service watchdog is enabled with the macro RV_PLIC_CLAIM_TIMEOUT_EN.
module rv_plic_claim_ctrl #(
    parameter int N_SOURCE    = 32,
    parameter int PRIO_W      = 3,
    parameter int ID_W        = $clog2(N_SOURCE + 1),
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    rv_plic_claim_ctrl_if.master   bus
);

    typedef enum logic [2:0] {IDLE, CLAIM, OFFER, SERVICE, COMPLETE} state_t;

    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 2");
    end

    state_t              state;
    logic [ID_W-1:0]     id_q;
    logic [N_SOURCE-1:0] elig;
    logic [ID_W-1:0]     win_id;
    logic [PRIO_W-1:0]   win_prio;

    function automatic logic [N_SOURCE-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        id_to_onehot = '0;
        if (id != '0) id_to_onehot[int'(id) - 1] = 1'b1;
    endfunction

    // A strict greater-than on the running best makes ties resolve to the lowest index.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        elig     = '0;
        win_id   = '0;
        win_prio = '0;
        for (int i = 0; i < N_SOURCE; i++) begin
            elig[i] = bus.ip[i] & bus.ie[i] & (bus.prio[i*PRIO_W +: PRIO_W] > bus.threshold);
            if (elig[i] && (win_id == '0 || bus.prio[i*PRIO_W +: PRIO_W] > win_prio)) begin
                win_id   = ID_W'(i + 1);
                win_prio = bus.prio[i*PRIO_W +: PRIO_W];
            end
        end
    end

    assign bus.irq_o = |elig;

`ifdef RV_PLIC_CLAIM_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYC - 1);
    logic [WD_W-1:0] wd_q;
`else
    assign bus.timeout_o = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state           <= IDLE;
            id_q            <= '0;
            bus.claim       <= '0;
            bus.complete    <= '0;
            bus.svc_valid_o <= 1'b0;
            bus.svc_id_o    <= '0;
            bus.busy_o      <= 1'b0;
`ifdef RV_PLIC_CLAIM_TIMEOUT_EN
            wd_q            <= '0;
            bus.timeout_o   <= 1'b0;
`endif
        end else begin
            // Pulse outputs drop by default. This keeps claim and complete to exactly one cycle.
            bus.claim    <= '0;
            bus.complete <= '0;
`ifdef RV_PLIC_CLAIM_TIMEOUT_EN
            bus.timeout_o <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (bus.irq_o) begin
                        id_q       <= win_id;
                        bus.claim  <= id_to_onehot(win_id);
                        bus.busy_o <= 1'b1;
                        state      <= CLAIM;
                    end
                end
                CLAIM: begin
                    bus.svc_valid_o <= 1'b1;
                    bus.svc_id_o    <= id_q;
                    state           <= OFFER;
                end
                OFFER: begin
                    if (bus.svc_ready_i) begin
                        bus.svc_valid_o <= 1'b0;
`ifdef RV_PLIC_CLAIM_TIMEOUT_EN
                        wd_q            <= '0;
`endif
                        state           <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (bus.done_i) begin
                        bus.complete <= id_to_onehot(id_q);
                        state        <= COMPLETE;
`ifdef RV_PLIC_CLAIM_TIMEOUT_EN
                    end else if (wd_q == WD_LIMIT) begin
                        bus.complete  <= id_to_onehot(id_q);
                        bus.timeout_o <= 1'b1;
                        state         <= COMPLETE;
                    end else begin
                        wd_q <= wd_q + 1'b1;
`endif
                    end
                end
                COMPLETE: begin
                    bus.svc_id_o <= '0;
                    bus.busy_o   <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_plic_claim_ctrl.sv
// Self-checking bench for rv_plic_claim_ctrl. It applies table vectors, hand sequences and random traffic.
// The random traffic is checked against a priority-scan reference model.
module tb_rv_plic_claim_ctrl;

    logic clk_i = 1'b0;
    logic rst_ni;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_i = ~clk_i;

    rv_plic_claim_ctrl_if #(.N_SOURCE(32), .PRIO_W(3)) bus ();

    rv_plic_claim_ctrl #(.N_SOURCE(32), .PRIO_W(3), .TIMEOUT_CYC(16)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] ip;
        logic [31:0] ie;
        logic [95:0] prio;
        logic [2:0]  thr;
        logic        exp_irq;
        logic [5:0]  exp_id;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [95:0] pset(input logic [95:0] base, input int idx, input logic [2:0] v);
        logic [95:0] r;
        r = base;
        r[idx*3 +: 3] = v;
        return r;
    endfunction

    function automatic logic [31:0] oh(input logic [5:0] id);
        logic [31:0] r;
        r = '0;
        if (id != 0) r[int'(id) - 1] = 1'b1;
        return r;
    endfunction

    // Reference model: scan priority levels from highest to lowest, and sources in index order within a level.
    function automatic logic [5:0] ref_winner(input logic [31:0] ip, input logic [31:0] ie,
                                              input logic [95:0] prio, input logic [2:0] thr);
        for (int p = 7; p > int'(thr); p--)
            for (int i = 0; i < 32; i++)
                if (ip[i] && ie[i] && int'(prio[i*3 +: 3]) == p) return 6'(i + 1);
        return 6'd0;
    endfunction

    task automatic scramble();
        bus.ip        = $urandom;
        bus.ie        = $urandom;
        bus.prio      = {$urandom, $urandom, $urandom};
        bus.threshold = 3'($urandom_range(0, 7));
    endtask

    // Starts in the CLAIM cycle and walks the handshake through OFFER, leaving the design in SERVICE.
    task automatic to_service(input logic [5:0] id);
        bus.ip = '0;
        tick();
        check("offer_valid", 64'(bus.svc_valid_o), 64'd1);
        check("offer_id", 64'(bus.svc_id_o), 64'(id));
        check("offer_claim_clear", 64'(bus.claim), 64'd0);
        bus.svc_ready_i = 1'b1;
        tick();
        bus.svc_ready_i = 1'b0;
        check("service_valid_low", 64'(bus.svc_valid_o), 64'd0);
        check("service_id", 64'(bus.svc_id_o), 64'(id));
    endtask

    task automatic finish_txn(input logic [5:0] id);
        to_service(id);
        bus.done_i = 1'b1;
        tick();
        bus.done_i = 1'b0;
        check("complete_pulse", 64'(bus.complete), 64'(oh(id)));
        check("complete_no_timeout", 64'(bus.timeout_o), 64'd0);
        tick();
        check("idle_complete_clear", 64'(bus.complete), 64'd0);
        check("idle_busy", 64'(bus.busy_o), 64'd0);
        check("idle_svc_id", 64'(bus.svc_id_o), 64'd0);
    endtask

    always @(negedge clk_i) begin
        if (rst_ni === 1'b1) begin
            check("claim_onehot0", 64'($onehot0(bus.claim)), 64'd1);
            check("complete_onehot0", 64'($onehot0(bus.complete)), 64'd1);
            check("claim_complete_excl", 64'((bus.claim != 0) && (bus.complete != 0)), 64'd0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL tb_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int   k;
        int   stray;
        logic [5:0] exp_id;

        vecs[0] = '{32'h16, '1, pset(pset(pset('0, 1, 3), 2, 5), 4, 5), 3'd0, 1'b1, 6'd3};
        vecs[1] = '{32'h12, '1, pset(pset(pset('0, 1, 3), 2, 5), 4, 5), 3'd0, 1'b1, 6'd5};
        vecs[2] = '{32'h1,  '0, pset('0, 0, 5),                          3'd0, 1'b0, 6'd0};
        vecs[3] = '{32'h1,  '1, pset('0, 0, 4),                          3'd4, 1'b0, 6'd0};
        vecs[4] = '{32'h1,  '1, pset('0, 0, 5),                          3'd4, 1'b1, 6'd1};
        vecs[5] = '{'1,     '1, '1,                                      3'd7, 1'b0, 6'd0};
        vecs[6] = '{32'h8000_0000, '1, '0,                               3'd0, 1'b0, 6'd0};
        vecs[7] = '{32'h8000_0001, '1, pset(pset('0, 31, 7), 0, 6),      3'd5, 1'b1, 6'd32};
        vecs[8] = '{32'h8000_0000, '1, pset('0, 31, 1),                  3'd0, 1'b1, 6'd32};

        rst_ni          = 1'b0;
        bus.ip          = '0;
        bus.ie          = '0;
        bus.prio        = '0;
        bus.threshold   = '0;
        bus.svc_ready_i = 1'b0;
        bus.done_i      = 1'b0;
        #12;
        check("rst_claim", 64'(bus.claim), 64'd0);
        check("rst_complete", 64'(bus.complete), 64'd0);
        check("rst_valid", 64'(bus.svc_valid_o), 64'd0);
        check("rst_id", 64'(bus.svc_id_o), 64'd0);
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        check("rst_timeout", 64'(bus.timeout_o), 64'd0);
        rst_ni = 1'b1;
        tick();

        // Setup and handshake: ready is held back, then done arrives at cycle 10.
        bus.ip = 32'h8; bus.ie = '1; bus.prio = pset('0, 3, 2); bus.threshold = 3'd1;
        tick();
        check("setup_claim", 64'(bus.claim), 64'h8);
        bus.ip = '0;
        tick();
        check("setup_valid", 64'(bus.svc_valid_o), 64'd1);
        check("setup_id", 64'(bus.svc_id_o), 64'd4);
        repeat (5) begin
            tick();
            check("hold_valid", 64'(bus.svc_valid_o), 64'd1);
            check("hold_id", 64'(bus.svc_id_o), 64'd4);
        end
        bus.svc_ready_i = 1'b1;
        tick();
        bus.svc_ready_i = 1'b0;
        check("hs_valid_low", 64'(bus.svc_valid_o), 64'd0);
        tick();
        tick();
        check("hs_no_early_complete", 64'(bus.complete), 64'd0);
        bus.done_i = 1'b1;
        tick();
        bus.done_i = 1'b0;
        check("hs_complete", 64'(bus.complete), 64'h8);
        check("hs_busy_in_complete", 64'(bus.busy_o), 64'd1);
        tick();
        check("hs_complete_once", 64'(bus.complete), 64'd0);
        check("hs_busy_low", 64'(bus.busy_o), 64'd0);

        for (int v = 0; v < 9; v++) begin
            bus.ip = vecs[v].ip; bus.ie = vecs[v].ie;
            bus.prio = vecs[v].prio; bus.threshold = vecs[v].thr;
            #1;
            check($sformatf("vec%0d_irq", v), 64'(bus.irq_o), 64'(vecs[v].exp_irq));
            tick();
            check($sformatf("vec%0d_claim", v), 64'(bus.claim), 64'(oh(vecs[v].exp_id)));
            check($sformatf("vec%0d_busy", v), 64'(bus.busy_o), 64'(vecs[v].exp_id != 0));
            if (vecs[v].exp_id != 0) finish_txn(vecs[v].exp_id);
        end

        // Reset arrives in SERVICE: no complete may follow, and the next claim must be fresh.
        bus.ip = 32'h4; bus.ie = '1; bus.prio = pset('0, 2, 3); bus.threshold = 3'd0;
        tick();
        check("rsv_claim", 64'(bus.claim), 64'h4);
        to_service(6'd3);
        #2 rst_ni = 1'b0;
        #1;
        check("rsv_claim0", 64'(bus.claim), 64'd0);
        check("rsv_complete0", 64'(bus.complete), 64'd0);
        check("rsv_valid0", 64'(bus.svc_valid_o), 64'd0);
        check("rsv_id0", 64'(bus.svc_id_o), 64'd0);
        check("rsv_busy0", 64'(bus.busy_o), 64'd0);
        check("rsv_timeout0", 64'(bus.timeout_o), 64'd0);
        #2 rst_ni = 1'b1;
        bus.ip = 32'h1; bus.prio = pset('0, 0, 5);
        tick();
        check("rsv_fresh_claim", 64'(bus.claim), 64'h1);
        check("rsv_no_stray_complete", 64'(bus.complete), 64'd0);
        finish_txn(6'd1);

        // Watchdog behaviour when the agent never signals done.
        bus.ip = 32'h2; bus.prio = pset('0, 1, 1); bus.threshold = 3'd0;
        tick();
        check("wd_claim", 64'(bus.claim), 64'h2);
        to_service(6'd2);
`ifdef RV_PLIC_CLAIM_TIMEOUT_EN
        stray = 0;
        repeat (15) begin
            if (bus.complete != 0 || bus.timeout_o) stray++;
            tick();
        end
        check("wd_no_early", 64'(stray), 64'd0);
        check("wd_last_wait", 64'(bus.complete), 64'd0);
        tick();
        check("wd_complete", 64'(bus.complete), 64'h2);
        check("wd_timeout", 64'(bus.timeout_o), 64'd1);
        tick();
        check("wd_timeout_once", 64'(bus.timeout_o), 64'd0);
        check("wd_idle", 64'(bus.busy_o), 64'd0);
        bus.ip = 32'h2;
        tick();
        check("wd2_claim", 64'(bus.claim), 64'h2);
        to_service(6'd2);
        repeat (15) tick();
        bus.done_i = 1'b1;
        tick();
        bus.done_i = 1'b0;
        check("wd2_complete", 64'(bus.complete), 64'h2);
        check("wd2_no_timeout", 64'(bus.timeout_o), 64'd0);
        tick();
        check("wd2_idle", 64'(bus.busy_o), 64'd0);
`else
        stray = 0;
        repeat (120) begin
            tick();
            if (bus.complete != 0 || bus.timeout_o) stray++;
        end
        check("nowd_no_complete", 64'(stray), 64'd0);
        check("nowd_busy", 64'(bus.busy_o), 64'd1);
        bus.done_i = 1'b1;
        tick();
        bus.done_i = 1'b0;
        check("nowd_complete", 64'(bus.complete), 64'h2);
        tick();
        check("nowd_idle", 64'(bus.busy_o), 64'd0);
`endif

        // Random traffic: inputs are also scrambled while busy and must not disturb the latched ID.
        for (int it = 0; it < 60; it++) begin
            bus.ip        = $urandom & $urandom;
            bus.ie        = $urandom | $urandom;
            for (int i = 0; i < 32; i++) bus.prio[i*3 +: 3] = 3'($urandom_range(0, 7));
            bus.threshold = 3'($urandom_range(0, 6));
            exp_id = ref_winner(bus.ip, bus.ie, bus.prio, bus.threshold);
            #1;
            check("rnd_irq", 64'(bus.irq_o), 64'(exp_id != 0));
            tick();
            check("rnd_claim", 64'(bus.claim), 64'(oh(exp_id)));
            if (exp_id == 0) begin
                check("rnd_idle_busy", 64'(bus.busy_o), 64'd0);
                continue;
            end
            scramble();
            tick();
            k = $urandom_range(0, 3);
            repeat (k) begin
                check("rnd_offer_valid", 64'(bus.svc_valid_o), 64'd1);
                check("rnd_offer_id", 64'(bus.svc_id_o), 64'(exp_id));
                bus.done_i = 1'($urandom_range(0, 1));
                scramble();
                tick();
            end
            check("rnd_offer_valid", 64'(bus.svc_valid_o), 64'd1);
            check("rnd_offer_id", 64'(bus.svc_id_o), 64'(exp_id));
            bus.svc_ready_i = 1'b1;
            bus.done_i      = 1'($urandom_range(0, 1));
            tick();
            bus.svc_ready_i = 1'b0;
            bus.done_i      = 1'b0;
            k = $urandom_range(0, 3);
            repeat (k) begin
                check("rnd_service_wait", 64'(bus.complete), 64'd0);
                scramble();
                tick();
            end
            check("rnd_service_id", 64'(bus.svc_id_o), 64'(exp_id));
            check("rnd_service_wait", 64'(bus.complete), 64'd0);
            bus.done_i = 1'b1;
            tick();
            bus.done_i = 1'b0;
            bus.ip     = '0;
            check("rnd_complete", 64'(bus.complete), 64'(oh(exp_id)));
            tick();
            check("rnd_idle", 64'(bus.busy_o), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
